hazard_ctrl_unit: RTL and testbench

//  Unified pipeline hazard controller for the 5-stage core (F/D/E/M/W). Merges load-use stall, M/W->E

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_mul_scoreboard.sv | 64 ++++++
 rtl/hazard_ctrl_unit.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard-control types: forwarding mux encodings,
// default register address width and the register match helper.
package hazard_pkg;

  localparam int REG_AW_DEF = 4;
  localparam int MAX_AW     = 8;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Register 0 never matches when it is hard-wired zero.
  function automatic logic match(
    input logic [MAX_AW-1:0] x,
    input logic [MAX_AW-1:0] y,
    input logic              zr
  );
    return (x == y) && !(zr && (x == '0));
  endfunction

endpackage

// File: rtl/hazard_mul_scoreboard.sv
// Multi-cycle multiplier scoreboard: latency counter, pending destination.
// Ports: fire_* (issuing multiply), mul_busy/mul_wb/mul_wb_rd, pend_vld/pend_rd.
module hazard_mul_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MUL_LAT  = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fire_mul,
  input  logic              fire_we,
  input  logic [REG_AW-1:0] fire_rd,
  output logic              mul_busy,
  output logic              mul_wb,
  output logic [REG_AW-1:0] mul_wb_rd,
  output logic              pend_vld,
  output logic [REG_AW-1:0] pend_rd
);

  localparam int   CW = $clog2(MUL_LAT + 1);
  localparam logic ZR = (ZERO_REG != 0);

  logic [CW-1:0]     mul_cnt_q, mul_cnt_d;
  logic              pend_vld_q, pend_vld_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic              fire_wr;

  assign fire_wr = fire_we && !(ZR && (fire_rd == '0));

  always_comb begin
    mul_cnt_d  = mul_cnt_q;
    pend_vld_d = pend_vld_q;
    pend_rd_d  = pend_rd_q;
    if (mul_cnt_q != '0) mul_cnt_d = mul_cnt_q - CW'(1);
    if (mul_cnt_q == CW'(1)) pend_vld_d = 1'b0;
    // A new issue on the completion cycle wins over the clear.
    if (fire_mul) begin
      mul_cnt_d  = CW'(MUL_LAT);
      pend_vld_d = fire_wr;
      if (fire_wr) pend_rd_d = fire_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_cnt_q  <= '0;
      pend_vld_q <= 1'b0;
      pend_rd_q  <= '0;
    end else begin
      mul_cnt_q  <= mul_cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_rd_q  <= pend_rd_d;
    end
  end

  assign mul_busy  = (mul_cnt_q != '0);
  assign mul_wb    = (mul_cnt_q == CW'(1));
  assign mul_wb_rd = mul_wb ? pend_rd_q : '0;
  assign pend_vld  = pend_vld_q;
  assign pend_rd   = pend_rd_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use/mul stalls, M/W->E forwarding, branch flush window.
// Ports: D/E/M/W register info in; stall/flush/forward selects and mul status out.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MUL_LAT     = 3,
  parameter int FLUSH_EXTRA = 2,
  parameter int ZERO_REG    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              rs1_vld_d,
  input  logic              rs2_vld_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              we_d,
  input  logic              mul_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              we_e,
  input  logic              load_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              we_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              we_w,
  input  logic              branch_taken_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_ctrl_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              mul_busy,
  output logic              mul_wb,
  output logic [REG_AW-1:0] mul_wb_rd
);

  localparam logic ZR  = (ZERO_REG != 0);
  localparam int   FCW = 4;

  function automatic logic m(
    input logic [REG_AW-1:0] x,
    input logic [REG_AW-1:0] y
  );
    return match(MAX_AW'(x), MAX_AW'(y), ZR);
  endfunction

  logic [FCW-1:0]    flush_cnt_q, flush_cnt_d;
  logic              flush_act, stall_any, stall;
  logic              lu, raw, waw, strc, fire;
  logic              sb_busy, sb_wb, pend_vld;
  logic [REG_AW-1:0] sb_wb_rd, pend_rd;
  logic [1:0]        fa, fb;

  always_comb begin
    fa = FWD_RF;
    if (we_m && m(rs1_e, rd_m))      fa = FWD_M;
    else if (we_w && m(rs1_e, rd_w)) fa = FWD_W;
    fb = FWD_RF;
    if (we_m && m(rs2_e, rd_m))      fb = FWD_M;
    else if (we_w && m(rs2_e, rd_w)) fb = FWD_W;
  end

  always_comb begin
    lu  = we_e && load_e &&
          ((rs1_vld_d && m(rs1_d, rd_e)) ||
           (rs2_vld_d && m(rs2_d, rd_e)));
    raw = pend_vld &&
          ((rs1_vld_d && m(rs1_d, pend_rd)) ||
           (rs2_vld_d && m(rs2_d, pend_rd)));
    waw = pend_vld && we_d && m(rd_d, pend_rd);
    // Issue is allowed on the completion cycle of the previous multiply.
    strc = mul_d && sb_busy && !sb_wb;
    stall_any = lu || raw || waw || strc;
  end

  assign flush_act = branch_taken_e || (flush_cnt_q != '0);
  assign stall     = stall_any && !flush_act;
  assign fire      = mul_d && !stall && !flush_act && !reset;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (branch_taken_e)            flush_cnt_d = FCW'(FLUSH_EXTRA);
    else if (flush_cnt_q != '0)    flush_cnt_d = flush_cnt_q - FCW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) flush_cnt_q <= '0;
    else       flush_cnt_q <= flush_cnt_d;
  end

  hazard_mul_scoreboard #(
    .REG_AW   (REG_AW),
    .MUL_LAT  (MUL_LAT),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .fire_mul  (fire),
    .fire_we   (we_d),
    .fire_rd   (rd_d),
    .mul_busy  (sb_busy),
    .mul_wb    (sb_wb),
    .mul_wb_rd (sb_wb_rd),
    .pend_vld  (pend_vld),
    .pend_rd   (pend_rd)
  );

  // Everything reads as idle while reset is held.
  assign stall_f      = !reset && stall;
  assign stall_d      = !reset && stall;
  assign flush_ctrl_d = !reset && stall;
  assign flush_d      = !reset && flush_act;
  assign flush_e      = !reset && flush_act;
  assign fwd_a_e      = reset ? FWD_RF : fa;
  assign fwd_b_e      = reset ? FWD_RF : fb;
  assign mul_busy     = !reset && sb_busy;
  assign mul_wb       = !reset && sb_wb;
  assign mul_wb_rd    = reset ? '0 : sb_wb_rd;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus random
// traffic against a cycle-stamp reference model.
module tb_hazard_ctrl_unit;

  localparam int AW = 4;
  localparam int LAT = 3;
  localparam int FE = 2;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic rs1_vld_d, rs2_vld_d, we_d, mul_d, we_e, load_e, we_m, we_w, br;
  logic stall_f, stall_d, flush_ctrl_d, flush_d, flush_e, mul_busy, mul_wb;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [AW-1:0] mul_wb_rd;

  hazard_ctrl_unit #(
    .REG_AW(AW), .MUL_LAT(LAT), .FLUSH_EXTRA(FE), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_vld_d(rs1_vld_d), .rs2_vld_d(rs2_vld_d),
    .rd_d(rd_d), .we_d(we_d), .mul_d(mul_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .we_e(we_e), .load_e(load_e),
    .rd_m(rd_m), .we_m(we_m), .rd_w(rd_w), .we_w(we_w),
    .branch_taken_e(br),
    .stall_f(stall_f), .stall_d(stall_d),
    .flush_ctrl_d(flush_ctrl_d),
    .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mul_busy(mul_busy), .mul_wb(mul_wb),
    .mul_wb_rd(mul_wb_rd)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  // Model state as absolute cycle stamps.
  int done_cyc = -100;
  int flush_until = -100;
  bit pend_w = 0;
  int pend_r = 0;
  bit e_stall, e_flush;
  // Last sampled DUT values for scenario-level checks.
  logic s_stall, s_flush, s_wb, s_busy;
  logic [1:0] s_fa;
  logic [AW-1:0] s_wbrd;

  function automatic bit mt(int x, int y);
    return (x == y) && (x != 0);
  endfunction

  function automatic int fsel(int rs);
    if (we_m && mt(rs, int'(rd_m))) return 2;
    if (we_w && mt(rs, int'(rd_w))) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clr();
    reset = 0; br = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0;
    rs1_vld_d = 0; rs2_vld_d = 0; we_d = 0; mul_d = 0;
    we_e = 0; load_e = 0; we_m = 0; we_w = 0;
  endtask

  task automatic step(input string tag);
    bit busy, one, pv, lu, raw, waw, st;
    int ea, eb, ewr;
    @(negedge clk);
    busy = cyc <= done_cyc;
    one  = cyc == done_cyc;
    pv   = pend_w && busy;
    lu  = we_e && load_e && ((rs1_vld_d && mt(int'(rs1_d), int'(rd_e))) ||
                             (rs2_vld_d && mt(int'(rs2_d), int'(rd_e))));
    raw = pv && ((rs1_vld_d && mt(int'(rs1_d), pend_r)) ||
                 (rs2_vld_d && mt(int'(rs2_d), pend_r)));
    waw = pv && we_d && mt(int'(rd_d), pend_r);
    st  = lu || raw || waw || (mul_d && busy && !one);
    e_flush = !reset && (br || cyc <= flush_until);
    e_stall = !reset && st && !e_flush;
    ea = reset ? 0 : fsel(int'(rs1_e));
    eb = reset ? 0 : fsel(int'(rs2_e));
    ewr = (!reset && one) ? pend_r : 0;
    chk({tag, ":stall_f"}, 8'(stall_f), 8'(e_stall));
    chk({tag, ":stall_d"}, 8'(stall_d), 8'(e_stall));
    chk({tag, ":fctl_d"}, 8'(flush_ctrl_d), 8'(e_stall));
    chk({tag, ":flush_d"}, 8'(flush_d), 8'(e_flush));
    chk({tag, ":flush_e"}, 8'(flush_e), 8'(e_flush));
    chk({tag, ":fwd_a"}, 8'(fwd_a_e), 8'(ea));
    chk({tag, ":fwd_b"}, 8'(fwd_b_e), 8'(eb));
    chk({tag, ":busy"}, 8'(mul_busy), 8'(!reset && busy));
    chk({tag, ":wb"}, 8'(mul_wb), 8'(!reset && one));
    chk({tag, ":wb_rd"}, 8'(mul_wb_rd), 8'(ewr));
    s_stall = stall_d; s_flush = flush_d; s_wb = mul_wb;
    s_busy = mul_busy; s_fa = fwd_a_e; s_wbrd = mul_wb_rd;
    @(posedge clk);
    if (reset) begin
      done_cyc = -100; flush_until = -100; pend_w = 0; pend_r = 0;
    end else begin
      if (br) flush_until = cyc + FE;
      if (mul_d && !e_stall && !e_flush) begin
        done_cyc = cyc + LAT;
        pend_w = we_d && (rd_d != 0);
        if (pend_w) pend_r = int'(rd_d);
      end
    end
    cyc++;
    #1;
  endtask

  int nfl, nst;

  initial begin
    clr();
    reset = 1;
    @(posedge clk); #1;
    step("rst");
    chk("rst_stall", 8'(s_stall), 8'd0);
    chk("rst_busy", 8'(s_busy), 8'd0);
    reset = 0;
    step("idle");

    // 1: load-use
    rd_e = 3; we_e = 1; load_e = 1; rs1_d = 3; rs1_vld_d = 1;
    step("lu");
    chk("t1_stall", 8'(s_stall), 8'd1);
    we_e = 0; load_e = 0; rd_e = 0;
    step("lu_rel");
    chk("t1_rel", 8'(s_stall), 8'd0);
    clr();

    // 2: forwarding priority and zero register
    rs1_e = 5; rd_m = 5; we_m = 1; rd_w = 5; we_w = 1;
    step("fwd_m");
    chk("t2_m", 8'(s_fa), 8'd2);
    we_m = 0;
    step("fwd_w");
    chk("t2_w", 8'(s_fa), 8'd1);
    rs1_e = 0; rd_m = 0; rd_w = 0; we_m = 1;
    step("fwd_z");
    chk("t2_z", 8'(s_fa), 8'd0);
    clr();

    // 3: branch flush window masks a concurrent load-use stall
    br = 1; rd_e = 2; we_e = 1; load_e = 1; rs2_d = 2; rs2_vld_d = 1;
    nfl = 0; nst = 0;
    for (int i = 0; i < 5; i++) begin
      step("br");
      br = 0;
      nfl += int'(s_flush);
      if (i < 3) nst += int'(s_stall);
    end
    chk("t3_nflush", 8'(nfl), 8'(FE + 1));
    chk("t3_masked", 8'(nst), 8'd0);
    clr();

    // 4: mul r7, dependent stalls until after writeback
    mul_d = 1; we_d = 1; rd_d = 7;
    step("mul");
    clr(); rs1_d = 7; rs1_vld_d = 1;
    nst = 0;
    for (int i = 0; i < 3; i++) begin
      step("mul_dep");
      nst += int'(s_stall);
    end
    chk("t4_nstall", 8'(nst), 8'd3);
    chk("t4_wb", 8'(s_wb), 8'd1);
    chk("t4_wbrd", 8'(s_wbrd), 8'd7);
    step("mul_rel");
    chk("t4_rel", 8'(s_stall), 8'd0);
    clr();

    // 5: back-to-back multiply at completion cycle
    mul_d = 1; we_d = 1; rd_d = 4;
    step("b2b0");
    clr();
    step("b2b1");
    step("b2b2");
    mul_d = 1; we_d = 1; rd_d = 9;
    step("b2b3");
    chk("t5_wb", 8'(s_wbrd), 8'd4);
    chk("t5_nostall", 8'(s_stall), 8'd0);
    clr(); rs2_d = 9; rs2_vld_d = 1;
    step("b2b4");
    chk("t5_pend", 8'(s_stall), 8'd1);
    chk("t5_busy", 8'(s_busy), 8'd1);
    step("b2b5");
    step("b2b6");
    chk("t5_wb2", 8'(s_wbrd), 8'd9);
    clr();

    // 6: reset mid-operation
    mul_d = 1; we_d = 1; rd_d = 6;
    step("rm0");
    clr(); rs2_d = 6; rs2_vld_d = 1;
    step("rm1");
    reset = 1;
    step("rm2");
    reset = 0;
    step("rm3");
    chk("t6_rel", 8'(s_stall), 8'd0);
    chk("t6_nowb", 8'(s_wb), 8'd0);
    step("rm4");
    clr();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      br = ($urandom_range(0, 11) == 0);
      rs1_d = AW'($urandom_range(0, 3));
      rs2_d = AW'($urandom_range(0, 3));
      rd_d  = AW'($urandom_range(0, 3));
      rs1_e = AW'($urandom_range(0, 3));
      rs2_e = AW'($urandom_range(0, 3));
      rd_e  = AW'($urandom_range(0, 3));
      rd_m  = AW'($urandom_range(0, 3));
      rd_w  = AW'($urandom_range(0, 3));
      rs1_vld_d = 1'($urandom);
      rs2_vld_d = 1'($urandom);
      we_d = 1'($urandom);
      mul_d = ($urandom_range(0, 2) == 0);
      we_e = 1'($urandom);
      load_e = 1'($urandom);
      we_m = 1'($urandom);
      we_w = 1'($urandom);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
